spi_master_cfg: RTL and testbench

Parametrised SPI master, successor to the fixed 8-bit mode-0 SPI master used with the RC522 RFID reader. It adds configurable word width, SCK divider, all four CPOL/CPHA modes, MSB/LSB-first ordering and multiple chip selects. It also adds ready/start handshaking and multi-word bursts with CS held low. It sits between the RC522 command sequencer (and future SPI peripherals) and the SPI pins.

---
 rtl/spi_pkg.sv | 22 ++
 rtl/spi_clk_div.sv | 27 ++
 rtl/spi_master_cfg.sv | 173 +++++++++++++++++
 tb/tb_spi_master_cfg.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and helpers for the configurable SPI master.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        TAIL
    } state_t;

    // SPI mode encodings as {CPOL, CPHA}
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int unsigned cs_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_div.sv
// SCK half-period divider; tick marks the last clk cycle of each half-period.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt_q;

    assign tick = (cnt_q == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/spi_master_cfg.sv
// Configurable SPI master: word width, divider, CPOL/CPHA, bit order,
// multiple chip selects, and multi-word bursts with CS held in HOLD.
module spi_master_cfg
    import spi_pkg::*;
#(
    parameter int unsigned  DATA_W    = 8,
    parameter int unsigned  CLK_DIV   = 4,
    parameter bit           CPOL      = 1'b0,
    parameter bit           CPHA      = 1'b0,
    parameter bit           MSB_FIRST = 1'b1,
    parameter int unsigned  NUM_CS    = 1,
    localparam int unsigned CS_W      = cs_width(NUM_CS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic              last,
    input  logic [CS_W-1:0]   cs_sel,
    output logic [DATA_W-1:0] data_out,
    output logic              done,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int unsigned       EDGE_W      = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] LAST_EDGE   = EDGE_W'(2 * DATA_W - 1);
    localparam logic [1:0]        MODE        = {CPOL, CPHA};
    localparam bit                SAMPLE_LEAD = (MODE == MODE0) || (MODE == MODE2);
    localparam bit                SCK_IDLE    = (MODE == MODE2) || (MODE == MODE3);

    state_t             state_q;
    logic [DATA_W-1:0]  tx_q;
    logic [DATA_W-1:0]  rx_q;
    logic [DATA_W-1:0]  data_out_q;
    logic [EDGE_W-1:0]  edge_cnt_q;
    logic               last_q;
    logic               sck_q;
    logic               mosi_q;
    logic               done_q;
    logic               ready_q;
    logic [NUM_CS-1:0]  cs_n_q;

    logic               tick;
    logic               div_clear_c;
    logic               accept_c;
    logic               lead_edge_c;
    logic               final_edge_c;
    logic               sample_c;
    logic               drive_c;
    logic [DATA_W-1:0]  rx_shift_c;
    logic [DATA_W-1:0]  rx_nxt_c;
    logic [NUM_CS-1:0]  cs_dec_c;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_word(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear_c),
        .tick  (tick)
    );

    // Edge classification; the divider restarts on every state change
    always_comb begin
        accept_c     = start && ready_q;
        lead_edge_c  = ~edge_cnt_q[0];
        final_edge_c = (edge_cnt_q == LAST_EDGE);
        sample_c     = (state_q == SHIFT) && tick && (lead_edge_c == SAMPLE_LEAD);
        drive_c      = (state_q == SHIFT) && tick && (lead_edge_c != SAMPLE_LEAD)
                       && !final_edge_c;
        rx_shift_c   = MSB_FIRST ? {rx_q[DATA_W-2:0], miso} : {miso, rx_q[DATA_W-1:1]};
        rx_nxt_c     = sample_c ? rx_shift_c : rx_q;
        div_clear_c  = accept_c
                       || (tick && ((state_q == SETUP) || (state_q == TAIL)
                                    || ((state_q == SHIFT) && final_edge_c)));
    end

    // Out-of-range selects decode to no active line
    always_comb begin
        cs_dec_c = '0;
        for (int i = 0; i < int'(NUM_CS); i++) begin
            cs_dec_c[i] = (32'(cs_sel) == 32'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
            edge_cnt_q <= '0;
            last_q     <= 1'b0;
            sck_q      <= SCK_IDLE;
            mosi_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b1;
            cs_n_q     <= '1;
        end else begin
            done_q <= 1'b0;
            rx_q   <= rx_nxt_c;
            case (state_q)
                IDLE, HOLD: begin
                    // ready rises one cycle after a burst word completes
                    ready_q <= 1'b1;
                    if (accept_c) begin
                        ready_q <= 1'b0;
                        last_q  <= last;
                        state_q <= SETUP;
                        if (state_q == IDLE) begin
                            cs_n_q <= ~cs_dec_c;
                        end
                        if (!CPHA) begin
                            mosi_q <= first_bit(data_in);
                            tx_q   <= shift_word(data_in);
                        end else begin
                            tx_q   <= data_in;
                        end
                    end
                end
                SETUP: begin
                    if (tick) begin
                        edge_cnt_q <= '0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sck_q      <= ~sck_q;
                        edge_cnt_q <= edge_cnt_q + EDGE_W'(1);
                        if (drive_c) begin
                            mosi_q <= first_bit(tx_q);
                            tx_q   <= shift_word(tx_q);
                        end
                        if (final_edge_c) begin
                            done_q     <= 1'b1;
                            data_out_q <= rx_nxt_c;
                            state_q    <= last_q ? TAIL : HOLD;
                        end
                    end
                end
                TAIL: begin
                    if (tick) begin
                        cs_n_q  <= '1;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready    = ready_q;
    assign data_out = data_out_q;
    assign done     = done_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scenario bench for spi_master_cfg: three configurations with slave models
// and a per-instance scoreboard of expected received words.
module tb_spi_master_cfg;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // A: mode 0, 8 bit, CLK_DIV=2
    logic       start_a = 1'b0, last_a = 1'b0, ready_a, done_a, sck_a, mosi_a, miso_a;
    logic [7:0] din_a = '0, dout_a;
    logic [0:0] sel_a = '0, cs_n_a;
    // B: mode 3, 8 bit, CLK_DIV=1, loopback
    logic       start_b = 1'b0, last_b = 1'b0, ready_b, done_b, sck_b, mosi_b, miso_b;
    logic [7:0] din_b = '0, dout_b;
    logic [0:0] sel_b = '0, cs_n_b;
    // C: mode 0, 16 bit LSB first, 4 chip selects, loopback
    logic        start_c = 1'b0, last_c = 1'b0, ready_c, done_c, sck_c, mosi_c, miso_c;
    logic [15:0] din_c = '0, dout_c;
    logic [1:0]  sel_c = '0;
    logic [3:0]  cs_n_c;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
                     .MSB_FIRST(1'b1), .NUM_CS(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .ready(ready_a), .data_in(din_a),
        .last(last_a), .cs_sel(sel_a), .data_out(dout_a), .done(done_a),
        .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a));

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(1), .CPOL(1'b1), .CPHA(1'b1),
                     .MSB_FIRST(1'b1), .NUM_CS(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .ready(ready_b), .data_in(din_b),
        .last(last_b), .cs_sel(sel_b), .data_out(dout_b), .done(done_b),
        .sck(sck_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b));

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0),
                     .MSB_FIRST(1'b0), .NUM_CS(4)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .ready(ready_c), .data_in(din_c),
        .last(last_c), .cs_sel(sel_c), .data_out(dout_c), .done(done_c),
        .sck(sck_c), .mosi(mosi_c), .miso(miso_c), .cs_n(cs_n_c));

    // Mode-0 slave for A: presents resp MSB first, captures mosi on rising sck
    logic [7:0] slv_a_resp = 8'h00;
    logic [7:0] slv_a_rx   = 8'h00;
    int         slv_a_cnt  = 0;
    always @(negedge cs_n_a[0] or posedge sck_a) begin
        if (!sck_a) begin
            slv_a_cnt = 0;
            slv_a_rx  = 8'h00;
        end else if (!cs_n_a[0]) begin
            slv_a_rx  = {slv_a_rx[6:0], mosi_a};
            slv_a_cnt = slv_a_cnt + 1;
        end
    end
    assign miso_a = (slv_a_cnt < 8) ? slv_a_resp[3'(7 - slv_a_cnt)] : 1'b0;

    // Mode-3 slave for B: words assembled from rising sck, CS may span words
    logic [7:0] cap_b[$];
    logic [7:0] sh_b  = 8'h00;
    int         cnt_b = 0;
    always @(posedge sck_b) begin
        if (!cs_n_b[0]) begin
            sh_b  = {sh_b[6:0], mosi_b};
            cnt_b = cnt_b + 1;
            if (cnt_b == 8) begin
                cap_b.push_back(sh_b);
                cnt_b = 0;
            end
        end
    end
    assign miso_b = mosi_b;

    // C: history of mosi at rising sck, oldest bit of the last 16 in [15]
    logic [15:0] hist_c = 16'h0000;
    always @(posedge sck_c) if (!cs_n_c[2]) hist_c = {hist_c[14:0], mosi_c};
    assign miso_c = mosi_c;

    int toggles_a = 0, done_cnt_a = 0, done_cnt_b = 0, cs_rise_b = 0;
    always @(sck_a)          toggles_a  = toggles_a + 1;
    always @(posedge done_a) done_cnt_a = done_cnt_a + 1;
    always @(posedge done_b) done_cnt_b = done_cnt_b + 1;
    always @(posedge cs_n_b[0]) cs_rise_b = cs_rise_b + 1;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [15:0] exp_c[$];

    function automatic logic done_of(input int which);
        return (which == 0) ? done_a : (which == 1) ? done_b : done_c;
    endfunction

    task automatic launch(input int which, input logic [15:0] data, input logic lst,
                          input logic [1:0] sel);
        @(negedge clk);
        case (which)
            0:       begin din_a = data[7:0]; last_a = lst; sel_a = sel[0]; start_a = 1'b1; end
            1:       begin din_b = data[7:0]; last_b = lst; sel_b = sel[0]; start_b = 1'b1; end
            default: begin din_c = data;      last_c = lst; sel_c = sel;    start_c = 1'b1; end
        endcase
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    endtask

    // Cycles from accept until done is seen; -1 if it never arrives
    task automatic wait_done(input int which, input int lat0, output int lat);
        logic d;
        lat = lat0;
        d   = done_of(which);
        while (!d && lat < 400) begin
            @(negedge clk);
            lat = lat + 1;
            d   = done_of(which);
        end
        if (!d) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ready_a); else n_pass++;
        n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done: got %b exp 0", done_a); else n_pass++;
        n_checks++; if (cs_n_a !== 1'b1) $display("FAIL reset_cs_a: got %b exp 1", cs_n_a); else n_pass++;
        n_checks++; if (cs_n_c !== 4'hF) $display("FAIL reset_cs_c: got %h exp f", cs_n_c); else n_pass++;
        n_checks++; if (sck_a !== 1'b0) $display("FAIL reset_sck_a: got %b exp 0", sck_a); else n_pass++;
        n_checks++; if (sck_b !== 1'b1) $display("FAIL reset_sck_b: got %b exp 1", sck_b); else n_pass++;
        n_checks++; if (mosi_a !== 1'b0) $display("FAIL reset_mosi: got %b exp 0", mosi_a); else n_pass++;
        n_checks++; if (dout_a !== 8'h00) $display("FAIL reset_dout: got %h exp 00", dout_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ready_b !== 1'b1) $display("FAIL post_reset_ready_b: got %b exp 1", ready_b); else n_pass++;
    endtask

    task automatic test_mode0();
        int lat, n, t0, dc0;
        logic [7:0] e;
        slv_a_resp = 8'h3C;
        t0  = toggles_a;
        dc0 = done_cnt_a;
        exp_a.push_back(8'h3C);
        launch(0, 16'h00A5, 1'b1, 2'd0);
        wait_done(0, 1, lat);
        n_checks++; if (lat !== 35) $display("FAIL m0_latency: got %0d exp 35", lat); else n_pass++;
        e = (exp_a.size() != 0) ? exp_a.pop_front() : 8'hxx;
        n_checks++; if (dout_a !== e) $display("FAIL m0_data_out: got %h exp %h", dout_a, e); else n_pass++;
        n_checks++; if (slv_a_rx !== 8'hA5) $display("FAIL m0_mosi_bits: got %h exp a5", slv_a_rx); else n_pass++;
        n_checks++; if (toggles_a - t0 !== 16) $display("FAIL m0_sck_toggles: got %0d exp 16", toggles_a - t0); else n_pass++;
        n = 0;
        while (cs_n_a[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (n !== 2) $display("FAIL m0_cs_hold: got %0d exp 2", n); else n_pass++;
        n_checks++; if (done_cnt_a - dc0 !== 1) $display("FAIL m0_done_count: got %0d exp 1", done_cnt_a - dc0); else n_pass++;
    endtask

    task automatic test_burst_mode3();
        int lat, n, dc0, cr0, nw0;
        logic [7:0] e;
        dc0 = done_cnt_b;
        cr0 = cs_rise_b;
        nw0 = cap_b.size();
        n_checks++; if (sck_b !== 1'b1) $display("FAIL m3_sck_idle: got %b exp 1", sck_b); else n_pass++;
        exp_b.push_back(8'h12);
        launch(1, 16'h0012, 1'b0, 2'd0);
        wait_done(1, 1, lat);
        n_checks++; if (lat !== 18) $display("FAIL m3_latency_w0: got %0d exp 18", lat); else n_pass++;
        e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
        n_checks++; if (dout_b !== e) $display("FAIL m3_data_w0: got %h exp %h", dout_b, e); else n_pass++;
        n_checks++; if (ready_b !== 1'b0) $display("FAIL m3_ready_at_done: got %b exp 0", ready_b); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (ready_b !== 1'b1) $display("FAIL m3_ready_hold: got %b exp 1", ready_b); else n_pass++;
        n_checks++; if (cs_n_b !== 1'b0) $display("FAIL m3_cs_hold: got %b exp 0", cs_n_b); else n_pass++;
        n_checks++; if (sck_b !== 1'b1) $display("FAIL m3_sck_hold: got %b exp 1", sck_b); else n_pass++;
        exp_b.push_back(8'h34);
        launch(1, 16'h0034, 1'b1, 2'd0);
        wait_done(1, 1, lat);
        n_checks++; if (lat !== 18) $display("FAIL m3_latency_w1: got %0d exp 18", lat); else n_pass++;
        e = (exp_b.size() != 0) ? exp_b.pop_front() : 8'hxx;
        n_checks++; if (dout_b !== e) $display("FAIL m3_data_w1: got %h exp %h", dout_b, e); else n_pass++;
        n = 0;
        while (cs_n_b[0] !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (cs_rise_b - cr0 !== 1) $display("FAIL m3_cs_continuous: got %0d rises exp 1", cs_rise_b - cr0); else n_pass++;
        n_checks++; if (done_cnt_b - dc0 !== 2) $display("FAIL m3_done_count: got %0d exp 2", done_cnt_b - dc0); else n_pass++;
        n_checks++;
        if (cap_b.size() - nw0 !== 2) $display("FAIL m3_slave_words: got %0d words exp 2", cap_b.size() - nw0);
        else if (cap_b[nw0] !== 8'h12 || cap_b[nw0+1] !== 8'h34)
            $display("FAIL m3_slave_words: got %h %h exp 12 34", cap_b[nw0], cap_b[nw0+1]);
        else n_pass++;
    endtask

    task automatic test_wide_lsb();
        int lat, n;
        logic [15:0] e;
        exp_c.push_back(16'h8001);
        launch(2, 16'h8001, 1'b1, 2'd2);
        n_checks++; if (cs_n_c !== 4'b1011) $display("FAIL w16_cs_sel: got %b exp 1011", cs_n_c); else n_pass++;
        wait_done(2, 1, lat);
        n_checks++; if (lat !== 67) $display("FAIL w16_latency: got %0d exp 67", lat); else n_pass++;
        e = (exp_c.size() != 0) ? exp_c.pop_front() : 16'hxxxx;
        n_checks++; if (dout_c !== e) $display("FAIL w16_data_out: got %h exp %h", dout_c, e); else n_pass++;
        n_checks++; if (hist_c[15] !== 1'b1) $display("FAIL w16_first_bit: got %b exp 1", hist_c[15]); else n_pass++;
        n_checks++; if (hist_c[14] !== 1'b0) $display("FAIL w16_second_bit: got %b exp 0", hist_c[14]); else n_pass++;
        n = 0;
        while (cs_n_c !== 4'hF && n < 50) begin @(negedge clk); n++; end
        n_checks++; if (cs_n_c !== 4'hF) $display("FAIL w16_cs_release: got %b exp 1111", cs_n_c); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int lat, lat2, dc0;
        logic [7:0] e;
        slv_a_resp = 8'hC3;
        dc0 = done_cnt_a;
        exp_a.push_back(8'hC3);
        launch(0, 16'h0096, 1'b1, 2'd0);
        lat = 1;
        repeat (9) begin @(negedge clk); lat++; end
        din_a   = 8'hFF;
        start_a = 1'b1;
        repeat (5) begin
            n_checks++; if (ready_a !== 1'b0) $display("FAIL busy_ready: got %b exp 0", ready_a); else n_pass++;
            @(negedge clk);
            lat++;
        end
        start_a = 1'b0;
        din_a   = 8'h00;
        wait_done(0, lat, lat2);
        n_checks++; if (lat2 !== 35) $display("FAIL busy_latency: got %0d exp 35", lat2); else n_pass++;
        e = (exp_a.size() != 0) ? exp_a.pop_front() : 8'hxx;
        n_checks++; if (dout_a !== e) $display("FAIL busy_data_out: got %h exp %h", dout_a, e); else n_pass++;
        n_checks++; if (slv_a_rx !== 8'h96) $display("FAIL busy_word: got %h exp 96", slv_a_rx); else n_pass++;
        repeat (12) @(negedge clk);
        n_checks++; if (done_cnt_a - dc0 !== 1) $display("FAIL busy_done_count: got %0d exp 1", done_cnt_a - dc0); else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL busy_idle_ready: got %b exp 1", ready_a); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int lat, n, t0, dc0;
        logic [7:0] e;
        slv_a_resp = 8'h81;
        t0  = toggles_a;
        dc0 = done_cnt_a;
        launch(0, 16'h00C6, 1'b1, 2'd0);
        n = 0;
        while (toggles_a - t0 < 7 && n < 200) begin @(negedge clk); n++; end
        n_checks++; if (sck_a !== 1'b1) $display("FAIL rstmid_pre_sck: got %b exp 1", sck_a); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_checks++; if (cs_n_a !== 1'b1) $display("FAIL rstmid_cs: got %b exp 1", cs_n_a); else n_pass++;
        n_checks++; if (sck_a !== 1'b0) $display("FAIL rstmid_sck: got %b exp 0", sck_a); else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++; if (done_cnt_a !== dc0) $display("FAIL rstmid_no_done: got %0d exp %0d", done_cnt_a, dc0); else n_pass++;
        n_checks++; if (dout_a !== 8'h00) $display("FAIL rstmid_dout: got %h exp 00", dout_a); else n_pass++;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL rstmid_ready: got %b exp 1", ready_a); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        slv_a_resp = 8'hE7;
        exp_a.push_back(8'hE7);
        launch(0, 16'h005A, 1'b1, 2'd0);
        wait_done(0, 1, lat);
        n_checks++; if (lat !== 35) $display("FAIL rstmid_after_latency: got %0d exp 35", lat); else n_pass++;
        e = (exp_a.size() != 0) ? exp_a.pop_front() : 8'hxx;
        n_checks++; if (dout_a !== e) $display("FAIL rstmid_after_data: got %h exp %h", dout_a, e); else n_pass++;
        n_checks++; if (slv_a_rx !== 8'h5A) $display("FAIL rstmid_after_word: got %h exp 5a", slv_a_rx); else n_pass++;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0();
        test_burst_mode3();
        test_wide_lsb();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
